// File: rtl/controller_sequencer_if.sv
// SAP-1 control bus: opcode from the IR and the ring state plus control word
// driven back to the datapath. The master side is the controller_sequencer.
interface controller_sequencer_if;
    logic [3:0] opcode;
    logic [5:0] T;
    logic       C_P;
    logic       E_P;
    logic       L_M_bar;
    logic       CE_bar;
    logic       L_I_bar;
    logic       E_I_bar;
    logic       L_A_bar;
    logic       E_A;
    logic       S_U;
    logic       E_U;
    logic       L_B_bar;
    logic       L_O_bar;
    logic       HLT_bar;

    modport master (
        input  opcode,
        output T, C_P, E_P, L_M_bar, CE_bar, L_I_bar, E_I_bar,
               L_A_bar, E_A, S_U, E_U, L_B_bar, L_O_bar, HLT_bar
    );

    modport slave (
        output opcode,
        input  T, C_P, E_P, L_M_bar, CE_bar, L_I_bar, E_I_bar,
               L_A_bar, E_A, S_U, E_U, L_B_bar, L_O_bar, HLT_bar
    );
endinterface

// File: rtl/controller_sequencer.sv
// SAP-1 control unit: six-state one-hot ring (T1..T6) plus opcode decoder.
// Optional SINGLE_STEP_EN macro adds a STEP input that gates ring advance.
module controller_sequencer #(
    parameter logic [3:0] OP_LDA = 4'h0,
    parameter logic [3:0] OP_ADD = 4'h1,
    parameter logic [3:0] OP_SUB = 4'h2,
    parameter logic [3:0] OP_OUT = 4'hE,
    parameter logic [3:0] OP_HLT = 4'hF
) (
    input  logic                     CLK,
    input  logic                     CLR,
`ifdef SINGLE_STEP_EN
    input  logic                     STEP,
`endif
    controller_sequencer_if.master   bus
);

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } ring_t;

    typedef struct packed {
        logic C_P;
        logic E_P;
        logic L_M_bar;
        logic CE_bar;
        logic L_I_bar;
        logic E_I_bar;
        logic L_A_bar;
        logic E_A;
        logic S_U;
        logic E_U;
        logic L_B_bar;
        logic L_O_bar;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{
        C_P: 1'b0, E_P: 1'b0, L_M_bar: 1'b1, CE_bar: 1'b1, L_I_bar: 1'b1,
        E_I_bar: 1'b1, L_A_bar: 1'b1, E_A: 1'b0, S_U: 1'b0, E_U: 1'b0,
        L_B_bar: 1'b1, L_O_bar: 1'b1
    };

    ring_t t_q, t_d;
    logic  halted_q, halted_d;
    logic  advance;
    ctrl_t ctrl;

`ifdef SINGLE_STEP_EN
    assign advance = STEP;
`else
    assign advance = 1'b1;
`endif

    // HLT freezes the ring in T4 instead of rotating into T5.
    always_comb begin : next_state
        t_d      = t_q;
        halted_d = halted_q;
        if (!halted_q && advance) begin
            if (t_q == T4 && bus.opcode == OP_HLT) begin
                halted_d = 1'b1;
            end else begin
                t_d = ring_t'({t_q[4:0], t_q[5]});
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            t_q      <= T1;
            halted_q <= 1'b0;
        end else begin
            t_q      <= t_d;
            halted_q <= halted_d;
        end
    end

    // NOTE: ctrl starts from the inactive word so every path assigns every
    // field and no latch is inferred.
    always_comb begin : decode
        ctrl = CTRL_IDLE;
        if (!halted_q) begin
            case (t_q)
                T1: begin
                    ctrl.E_P     = 1'b1;
                    ctrl.L_M_bar = 1'b0;
                end
                T2: ctrl.C_P = 1'b1;
                T3: begin
                    ctrl.CE_bar  = 1'b0;
                    ctrl.L_I_bar = 1'b0;
                end
                T4: begin
                    case (bus.opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            ctrl.E_I_bar = 1'b0;
                            ctrl.L_M_bar = 1'b0;
                        end
                        OP_OUT: begin
                            ctrl.E_A     = 1'b1;
                            ctrl.L_O_bar = 1'b0;
                        end
                        default: ;
                    endcase
                end
                T5: begin
                    case (bus.opcode)
                        OP_LDA: begin
                            ctrl.CE_bar  = 1'b0;
                            ctrl.L_A_bar = 1'b0;
                        end
                        OP_ADD, OP_SUB: begin
                            ctrl.CE_bar  = 1'b0;
                            ctrl.L_B_bar = 1'b0;
                            ctrl.S_U     = (bus.opcode == OP_SUB);
                        end
                        default: ;
                    endcase
                end
                T6: begin
                    // S_U stays asserted from T5 so the subtracter output is settled.
                    if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
                        ctrl.E_U     = 1'b1;
                        ctrl.L_A_bar = 1'b0;
                        ctrl.S_U     = (bus.opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.T       = t_q;
    assign bus.C_P     = ctrl.C_P;
    assign bus.E_P     = ctrl.E_P;
    assign bus.L_M_bar = ctrl.L_M_bar;
    assign bus.CE_bar  = ctrl.CE_bar;
    assign bus.L_I_bar = ctrl.L_I_bar;
    assign bus.E_I_bar = ctrl.E_I_bar;
    assign bus.L_A_bar = ctrl.L_A_bar;
    assign bus.E_A     = ctrl.E_A;
    assign bus.S_U     = ctrl.S_U;
    assign bus.E_U     = ctrl.E_U;
    assign bus.L_B_bar = ctrl.L_B_bar;
    assign bus.L_O_bar = ctrl.L_O_bar;
    assign bus.HLT_bar = ~halted_q;

endmodule

// File: tb/tb_controller_sequencer.sv
// Bench for controller_sequencer: instruction-level model checked every cycle
// plus directed literal expectations; optional STEP test under SINGLE_STEP_EN.
module tb_controller_sequencer;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Bit positions of the "asserted" view of each output.
    localparam int A_HLT = 12, A_CP = 11, A_EP = 10, A_LM = 9, A_CE = 8, A_LI = 7;
    localparam int A_EI = 6, A_LA = 5, A_EA = 4, A_SU = 3, A_EU = 2, A_LB = 1, A_LO = 0;
    localparam logic [12:0] BAR_MASK = 13'b1001111100011;

    logic clk = 1'b0;
    logic clr;
`ifdef SINGLE_STEP_EN
    logic step;
`endif

    controller_sequencer_if bus_if ();

    controller_sequencer dut (
        .CLK (clk),
        .CLR (clr),
`ifdef SINGLE_STEP_EN
        .STEP(step),
`endif
        .bus (bus_if.master)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction-level model: step number 1..6 and a halted flag.
    int model_step  = 1;
    bit model_halt  = 1'b0;
    bit model_valid = 1'b0;

    always @(posedge clk) begin
        bit en;
`ifdef SINGLE_STEP_EN
        en = (step === 1'b1);
`else
        en = 1'b1;
`endif
        if (clr) begin
            model_step  = 1;
            model_halt  = 1'b0;
            model_valid = 1'b1;
        end else if (!model_halt && en) begin
            if (model_step == 4 && bus_if.opcode == OP_HLT) model_halt = 1'b1;
            else model_step = (model_step % 6) + 1;
        end
    end

    function automatic logic [12:0] expected_active(int st, logic [3:0] op, bit halted);
        logic [12:0] a;
        bool_arith: begin
            bit mem_op;
            bit alu_op;
            a      = '0;
            mem_op = (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB);
            alu_op = (op == OP_ADD) || (op == OP_SUB);
            if (halted) begin
                a[A_HLT] = 1'b1;
                return a;
            end
            if (st == 1) begin a[A_EP] = 1'b1; a[A_LM] = 1'b1; end
            if (st == 2) a[A_CP] = 1'b1;
            if (st == 3) begin a[A_CE] = 1'b1; a[A_LI] = 1'b1; end
            if (st == 4 && mem_op) begin a[A_EI] = 1'b1; a[A_LM] = 1'b1; end
            if (st == 4 && op == OP_OUT) begin a[A_EA] = 1'b1; a[A_LO] = 1'b1; end
            if (st == 5 && op == OP_LDA) begin a[A_CE] = 1'b1; a[A_LA] = 1'b1; end
            if (st == 5 && alu_op) begin a[A_CE] = 1'b1; a[A_LB] = 1'b1; end
            if (st == 6 && alu_op) begin a[A_EU] = 1'b1; a[A_LA] = 1'b1; end
            if ((st == 5 || st == 6) && op == OP_SUB) a[A_SU] = 1'b1;
        end
        return a;
    endfunction

    function automatic logic [12:0] dut_pins();
        return {bus_if.HLT_bar, bus_if.C_P, bus_if.E_P, bus_if.L_M_bar, bus_if.CE_bar,
                bus_if.L_I_bar, bus_if.E_I_bar, bus_if.L_A_bar, bus_if.E_A, bus_if.S_U,
                bus_if.E_U, bus_if.L_B_bar, bus_if.L_O_bar};
    endfunction

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_valid) begin
            int drivers;
            check("model_T", {26'd0, bus_if.T}, 32'd1 << (model_step - 1));
            check("model_ctrl", {19'd0, dut_pins()},
                  {19'd0, expected_active(model_step, bus_if.opcode, model_halt) ^ BAR_MASK});
            drivers = int'(bus_if.E_P) + int'(bus_if.E_A) + int'(bus_if.E_U)
                    + int'(!bus_if.CE_bar) + int'(!bus_if.E_I_bar);
            check("one_bus_driver", {31'd0, drivers <= 1}, 32'd1);
            check("T_onehot", $countones(bus_if.T), 32'd1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_edges(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        clr           = 1'b1;
        bus_if.opcode = OP_LDA;
`ifdef SINGLE_STEP_EN
        step          = 1'b1;
`endif
        // Reset: one CLR edge, T1 fetch word present afterwards.
        tick();
        clr = 1'b0;
        check("rst_T", {26'd0, bus_if.T}, 32'h01);
        check("rst_E_P", {31'd0, bus_if.E_P}, 32'd1);
        check("rst_L_M_bar", {31'd0, bus_if.L_M_bar}, 32'd0);
        check("rst_HLT_bar", {31'd0, bus_if.HLT_bar}, 32'd1);

        // ADD: walk T2..T6, then back to T1.
        bus_if.opcode = OP_ADD;
        for (int k = 1; k < 6; k++) begin
            tick();
            check("add_T", {26'd0, bus_if.T}, 32'd1 << k);
            if (k == 4) begin
                check("add_T5_L_B_bar", {31'd0, bus_if.L_B_bar}, 32'd0);
                check("add_T5_CE_bar", {31'd0, bus_if.CE_bar}, 32'd0);
            end
            if (k == 5) begin
                check("add_T6_E_U", {31'd0, bus_if.E_U}, 32'd1);
                check("add_T6_L_A_bar", {31'd0, bus_if.L_A_bar}, 32'd0);
                check("add_T6_S_U", {31'd0, bus_if.S_U}, 32'd0);
            end
        end
        tick();
        check("add_wrap_T", {26'd0, bus_if.T}, 32'h01);

        // SUB: S_U held in T5 and T6.
        bus_if.opcode = OP_SUB;
        run_edges(4);
        check("sub_T5_S_U", {31'd0, bus_if.S_U}, 32'd1);
        check("sub_T5_L_B_bar", {31'd0, bus_if.L_B_bar}, 32'd0);
        tick();
        check("sub_T6_S_U", {31'd0, bus_if.S_U}, 32'd1);
        check("sub_T6_E_U", {31'd0, bus_if.E_U}, 32'd1);
        tick();

        // LDA, OUT and an unknown opcode: one full instruction each.
        bus_if.opcode = OP_LDA;
        run_edges(4);
        check("lda_T5_L_A_bar", {31'd0, bus_if.L_A_bar}, 32'd0);
        run_edges(2);
        bus_if.opcode = OP_OUT;
        run_edges(3);
        check("out_T4_L_O_bar", {31'd0, bus_if.L_O_bar}, 32'd0);
        check("out_T4_E_A", {31'd0, bus_if.E_A}, 32'd1);
        run_edges(3);
        bus_if.opcode = 4'h7;
        run_edges(6);
        check("unk_wrap_T", {26'd0, bus_if.T}, 32'h01);

        // HLT: T4 inactive, then frozen in T4 with HLT_bar low.
        bus_if.opcode = OP_HLT;
        run_edges(3);
        check("hlt_T4_T", {26'd0, bus_if.T}, 32'h08);
        check("hlt_T4_L_M_bar", {31'd0, bus_if.L_M_bar}, 32'd1);
        check("hlt_T4_HLT_bar", {31'd0, bus_if.HLT_bar}, 32'd1);
        tick();
        check("halted_HLT_bar", {31'd0, bus_if.HLT_bar}, 32'd0);
        check("halted_T", {26'd0, bus_if.T}, 32'h08);
        run_edges(10);
        check("halted_T_held", {26'd0, bus_if.T}, 32'h08);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("unhalt_T", {26'd0, bus_if.T}, 32'h01);
        check("unhalt_HLT_bar", {31'd0, bus_if.HLT_bar}, 32'd1);

        // CLR during T5 of ADD abandons the instruction.
        bus_if.opcode = OP_ADD;
        run_edges(4);
        check("abort_T5_L_B_bar", {31'd0, bus_if.L_B_bar}, 32'd0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("abort_T", {26'd0, bus_if.T}, 32'h01);
        check("abort_L_B_bar", {31'd0, bus_if.L_B_bar}, 32'd1);
        run_edges(2);

`ifdef SINGLE_STEP_EN
        // Step gate: T holds while STEP=0; CLR still wins.
        clr  = 1'b1;
        step = 1'b0;
        tick();
        clr = 1'b0;
        check("step_clr_T", {26'd0, bus_if.T}, 32'h01);
        run_edges(5);
        check("step_hold_T", {26'd0, bus_if.T}, 32'h01);
        check("step_hold_E_P", {31'd0, bus_if.E_P}, 32'd1);
        step = 1'b1;
        tick();
        step = 1'b0;
        check("step_pulse_T", {26'd0, bus_if.T}, 32'h02);
        check("step_pulse_C_P", {31'd0, bus_if.C_P}, 32'd1);
        run_edges(3);
        check("step_idle_T", {26'd0, bus_if.T}, 32'h02);
`endif

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
